// File: rtl/bpsi_rx_unpack.sv
// bpsi_rx_unpack: validates BPSI frame length and repacks payload bytes MSB-first into 32-bit words
module bpsi_rx_unpack #(
  parameter real TCQ            = 0.1,
  parameter int  MAX_BYTES      = 8192,
  parameter int  TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slave_rx_byte_num_en_i,
  input  logic [15:0] slave_rx_byte_num_i,
  input  logic        slave_rx_byte_en_i,
  input  logic [7:0]  slave_rx_byte_i,
  output logic        rx_word_vld_o,
  output logic [31:0] rx_word_data_o,
  output logic        rx_word_last_o,
  output logic        rx_pkt_done_o,
  output logic [13:0] rx_word_cnt_o,
  output logic        rx_err_o,
  output logic [1:0]  rx_err_code_o,
  output logic        rx_busy_o
);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2;
  if (MAX_BYTES % 4 != 0 || MAX_BYTES > 65532 || TCQ < 0.0) begin : g_bad_param
    $error("bpsi_rx_unpack: MAX_BYTES must be a multiple of 4 below 65536");
  end
  logic        num_en, byte_en, legal, busy, take, recv, fin, tout, err_v;
  logic [15:0] num, cnt, h_cnt, tmo;
  logic [7:0]  byt;
  logic [1:0]  state, h_state, lane, h_lane, ecode;
  logic [13:0] wlen, h_wlen;
  logic [31:0] sr;
  assign num_en  = slave_rx_byte_num_en_i;
  assign num     = slave_rx_byte_num_i;
  assign byte_en = slave_rx_byte_en_i;
  assign byt     = slave_rx_byte_i;
  assign rx_busy_o = busy;
  // A header is applied first, so a byte in the same cycle belongs to the new frame
  always_comb begin
    busy    = state != IDLE;
    legal   = (|num) && (num[1:0] == 2'b00) && (num <= 16'(MAX_BYTES));
    h_state = num_en ? (legal ? RECV : (|num) ? DROP : IDLE) : state;
    h_cnt   = num_en ? num : cnt;
    h_lane  = num_en ? 2'd0 : lane;
    h_wlen  = num_en ? num[15:2] : wlen;
    take    = byte_en && h_state != IDLE;
    recv    = take && h_state == RECV;
    fin     = take && h_cnt == 16'd1;
    tout    = busy && !num_en && !byte_en && tmo == 16'(TIMEOUT_CYCLES);
    err_v   = (num_en && (!legal || busy)) || (byte_en && !num_en && !busy) || tout;
    ecode   = num_en ? (legal ? 2'd2 : 2'd1) : tout ? 2'd3 : 2'd0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      lane           <= '0;
      sr             <= '0;
      tmo            <= '0;
      wlen           <= '0;
      rx_word_vld_o  <= 1'b0;
      rx_word_data_o <= '0;
      rx_word_last_o <= 1'b0;
      rx_pkt_done_o  <= 1'b0;
      rx_word_cnt_o  <= '0;
      rx_err_o       <= 1'b0;
      rx_err_code_o  <= '0;
    end else begin
      state          <= (tout || fin) ? IDLE : h_state;
      cnt            <= take ? h_cnt - 16'd1 : h_cnt;
      lane           <= recv ? h_lane + 2'd1 : h_lane;
      sr             <= recv ? {sr[23:0], byt} : sr;
      tmo            <= (num_en || byte_en || !busy) ? '0 : tmo + 16'd1;
      wlen           <= h_wlen;
      rx_word_vld_o  <= recv && h_lane == 2'd3;
      rx_word_last_o <= recv && fin;
      rx_pkt_done_o  <= recv && fin;
      rx_err_o       <= err_v;
      if (recv && h_lane == 2'd3) rx_word_data_o <= {sr[23:0], byt};
      if (recv && fin) rx_word_cnt_o <= h_wlen;
      if (err_v) rx_err_code_o <= ecode;
    end
  end
endmodule
